// File: rtl/screensaver_pkg.sv
// Shared screen geometry, colour type, motion FSM states and colour sequencing
// for the screensaver box blocks.
package screensaver_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BOX_WIDTH     = 100;
  localparam int BOX_HEIGHT    = 100;
  localparam int XW            = $clog2(SCREEN_WIDTH);
  localparam int YW            = $clog2(SCREEN_HEIGHT);

  typedef logic [2:0] color_t;

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} motion_state_t;

  // Cycles 001..111; black is skipped so the box is always visible.
  function automatic color_t next_color(input color_t c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/box_motion_if.sv
// Frame-event inputs and published box state between video_timer,
// box_motion and the pixel-colour stage.
interface box_motion_if;
  import screensaver_pkg::*;

  logic [31:0]   frame;
  logic          pause;
  logic [XW-1:0] box_x;
  logic [YW-1:0] box_y;
  color_t        color;
  logic          bounce;
  logic          busy;

  modport master (output frame, pause, input box_x, box_y, color, bounce, busy);
  modport slave  (input frame, pause, output box_x, box_y, color, bounce, busy);
endinterface

// File: rtl/axis_step.sv
// One-axis position step with edge reflection. Limit and step size are inputs
// so a single instance can be time-shared between the x and y axes.
module axis_step #(
  parameter int W = 10
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic [W-1:0] max,
  input  logic [W-1:0] speed,
  output logic [W-1:0] pos_next,
  output logic         dir_next,
  output logic         hit
);

  logic signed [W+1:0] traj;
  logic signed [W+1:0] lim;

  always_comb begin
    lim = $signed({2'b00, max});
    if (dir) traj = $signed({2'b00, pos}) - $signed({2'b00, speed});
    else     traj = $signed({2'b00, pos}) + $signed({2'b00, speed});

    pos_next = traj[W-1:0];
    dir_next = dir;
    hit      = 1'b0;
    // Landing exactly on an edge counts as a hit.
    if (traj <= 0) begin
      pos_next = '0;
      dir_next = 1'b0;
      hit      = 1'b1;
    end else if (traj >= lim) begin
      pos_next = max;
      dir_next = 1'b1;
      hit      = 1'b1;
    end
  end

endmodule

// File: rtl/box_motion.sv
// Bounce-physics engine: steps the box once per frame-counter change and
// publishes position and colour together at COMMIT.
module box_motion
  import screensaver_pkg::*;
#(
  parameter int START_X = 50,
  parameter int START_Y = 50,
  parameter int SPEED_X = 2,
  parameter int SPEED_Y = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  box_motion_if.slave  bus
);

  localparam int MAX_X = SCREEN_WIDTH - BOX_WIDTH;
  localparam int MAX_Y = SCREEN_HEIGHT - BOX_HEIGHT;
  localparam int AW    = (XW > YW) ? XW : YW;

  motion_state_t state;
  logic [31:0]   frame_prev;
  logic [XW-1:0] x_work;
  logic [YW-1:0] y_work;
  logic          dir_x, dir_y, hit_x, hit_y;

  logic [AW-1:0] ax_pos, ax_max, ax_speed, ax_next;
  logic          ax_dir, ax_dir_next, ax_hit;

  // The single stepper serves x in MOVE_X and y in MOVE_Y.
  always_comb begin
    if (state == MOVE_Y) begin
      ax_pos   = AW'(y_work);
      ax_dir   = dir_y;
      ax_max   = AW'(MAX_Y);
      ax_speed = AW'(SPEED_Y);
    end else begin
      ax_pos   = AW'(x_work);
      ax_dir   = dir_x;
      ax_max   = AW'(MAX_X);
      ax_speed = AW'(SPEED_X);
    end
  end

  axis_step #(.W(AW)) u_step (
    .pos      (ax_pos),
    .dir      (ax_dir),
    .max      (ax_max),
    .speed    (ax_speed),
    .pos_next (ax_next),
    .dir_next (ax_dir_next),
    .hit      (ax_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_prev <= '1;
      x_work     <= XW'(START_X);
      y_work     <= YW'(START_Y);
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      hit_x      <= 1'b0;
      hit_y      <= 1'b0;
      bus.box_x  <= XW'(START_X);
      bus.box_y  <= YW'(START_Y);
      bus.color  <= 3'b111;
      bus.bounce <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.bounce <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.frame != frame_prev) begin
            frame_prev <= bus.frame;
            if (!bus.pause) begin
              state    <= MOVE_X;
              bus.busy <= 1'b1;
              x_work   <= bus.box_x;
              y_work   <= bus.box_y;
            end
          end
        end
        MOVE_X: begin
          x_work <= ax_next[XW-1:0];
          dir_x  <= ax_dir_next;
          hit_x  <= ax_hit;
          state  <= MOVE_Y;
        end
        MOVE_Y: begin
          y_work <= ax_next[YW-1:0];
          dir_y  <= ax_dir_next;
          hit_y  <= ax_hit;
          state  <= COMMIT;
        end
        COMMIT: begin
          bus.box_x <= x_work;
          bus.box_y <= y_work;
          if (hit_x || hit_y) begin
            bus.color  <= next_color(bus.color);
            bus.bounce <= 1'b1;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
